pipe_addsub: RTL and testbench

Parametrised, pipelined multi-bit adder/subtractor built as segmented carry-chain stages. It is the multi-bit, registered successor to the 1-bit full-adder cell in the cell library. Operands are split into SEG-bit segments. One segment resolves per pipeline stage, with the carry registered between stages, so throughput is one operation per clock at any WIDTH. It is intended as a soft adder macro for arithmetic benchmarks and for carry-chain verification in the FPGA fabric flow.

---
 rtl/pipe_addsub.sv | 152 +++++++++++++++
 tb/tb_pipe_addsub.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_addsub.sv
// pipe_addsub: pipelined adder/subtractor built from segmented carry-chain stages.
// Operands are cut into SEG-bit segments. Stage i resolves segment i and hands its carry
// to stage i+1 through a register. One operation is accepted per enabled clock. The
// result appears NSEG enabled edges after the operands are sampled.
//
// Parameters
//   WIDTH : operand/result width (must be a multiple of SEG)
//   SEG   : bits resolved per pipeline stage; NSEG = WIDTH/SEG stages
// Ports
//   ck        : clock, rising edge
//   rst       : asynchronous active-high reset, clears every register
//   en        : clock enable, 0 freezes every register
//   in_valid  : a/b/ci/sub carry a valid operation this cycle
//   a, b      : operands
//   ci        : carry-in (add) / borrow-in (subtract)
//   sub       : 0 add, 1 subtract
//   out_valid : sum/co/ovf were loaded by a completed operation on the last edge
//   sum       : result modulo 2^WIDTH
//   co        : carry-out of MSB (subtract: 1 = no borrow)
//   ovf       : two's-complement overflow
module pipe_addsub #(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input  logic             ck,
  input  logic             rst,
  input  logic             en,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             sub,
  output logic             out_valid,
  output logic [WIDTH-1:0] sum,
  output logic             co,
  output logic             ovf
);

  localparam int NSEG = WIDTH / SEG;

  logic [WIDTH-1:0] b_eff;
  logic             c0;

  // Subtraction is done as a + ~b + ~borrow_in, so the chain only ever adds.
  always_comb begin
    b_eff = b;
    c0    = ci;
    if (sub) begin
      b_eff = ~b;
      c0    = ~ci;
    end else begin
      b_eff = b;
      c0    = ci;
    end
  end

  for (genvar i = 0; i < NSEG; i++) begin : stg
    logic [SEG-1:0] a_seg;
    logic [SEG-1:0] b_seg;
    logic           c_in;
    logic           v_in;
    logic [SEG:0]   seg_res;

    // Stage 0 reads the ports directly; later stages read the previous stage register,
    // whose upper operand bits are the skew delay line for the still-unresolved segments.
    if (i == 0) begin : g_src
      assign a_seg = a[SEG-1:0];
      assign b_seg = b_eff[SEG-1:0];
      assign c_in  = c0;
      assign v_in  = in_valid;
    end else begin : g_src
      assign a_seg = stg[i-1].g_reg.a_hi_r[SEG-1:0];
      assign b_seg = stg[i-1].g_reg.b_hi_r[SEG-1:0];
      assign c_in  = stg[i-1].g_reg.c_r;
      assign v_in  = stg[i-1].g_reg.v_r;
    end

    assign seg_res = {1'b0, a_seg} + {1'b0, b_seg} + {{SEG{1'b0}}, c_in};

    if (i < NSEG - 1) begin : g_reg
      localparam int DONE = (i + 1) * SEG;  // low bits resolved once this stage registers
      localparam int LEFT = WIDTH - DONE;   // operand bits still waiting for later stages

      logic [DONE-1:0] lo_r;
      logic [LEFT-1:0] a_hi_r;
      logic [LEFT-1:0] b_hi_r;
      logic            c_r;
      logic            v_r;
      logic [DONE-1:0] lo_n;
      logic [LEFT-1:0] a_hi_n;
      logic [LEFT-1:0] b_hi_n;

      // Resolved low segments travel together, which is the output deskew.
      if (i == 0) begin : g_nxt
        assign lo_n   = seg_res[SEG-1:0];
        assign a_hi_n = a[WIDTH-1:SEG];
        assign b_hi_n = b_eff[WIDTH-1:SEG];
      end else begin : g_nxt
        assign lo_n   = {seg_res[SEG-1:0], stg[i-1].g_reg.lo_r};
        assign a_hi_n = stg[i-1].g_reg.a_hi_r[LEFT+SEG-1:SEG];
        assign b_hi_n = stg[i-1].g_reg.b_hi_r[LEFT+SEG-1:SEG];
      end

      // Stage register: advances on every enabled edge, valid or not.
      always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
          lo_r   <= {DONE{1'b0}};
          a_hi_r <= {LEFT{1'b0}};
          b_hi_r <= {LEFT{1'b0}};
          c_r    <= 1'b0;
          v_r    <= 1'b0;
        end else if (en) begin
          lo_r   <= lo_n;
          a_hi_r <= a_hi_n;
          b_hi_r <= b_hi_n;
          c_r    <= seg_res[SEG];
          v_r    <= v_in;
        end
      end
    end else begin : g_out
      logic [WIDTH-1:0] full;
      logic             c_msb;

      if (i == 0) begin : g_cat
        assign full = seg_res[SEG-1:0];
      end else begin : g_cat
        assign full = {seg_res[SEG-1:0], stg[i-1].g_reg.lo_r};
      end

      // Carry into the MSB recovered from the MSB sum bit: s = a ^ b ^ cin.
      assign c_msb = seg_res[SEG-1] ^ a_seg[SEG-1] ^ b_seg[SEG-1];

      // Output register: the token always advances, results load only for valid tokens.
      always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
          out_valid <= 1'b0;
          sum       <= {WIDTH{1'b0}};
          co        <= 1'b0;
          ovf       <= 1'b0;
        end else if (en) begin
          out_valid <= v_in;
          if (v_in) begin
            sum <= full;
            co  <= seg_res[SEG];
            ovf <= c_msb ^ seg_res[SEG];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_pipe_addsub.sv
// Self-checking bench for pipe_addsub (WIDTH=16, SEG=4, four stages).
module tb_pipe_addsub;

  logic        ck;
  logic        rst;
  logic        en;
  logic        in_valid;
  logic [15:0] a;
  logic [15:0] b;
  logic        ci;
  logic        sub;
  logic        out_valid;
  logic [15:0] sum;
  logic        co;
  logic        ovf;

  int checks;
  int errors;

  logic        exp_ov;
  logic [15:0] exp_sum;
  logic        exp_co;
  logic        exp_ovf;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        ci;
    logic        sub;
    logic [15:0] s;
    logic        co;
    logic        ovf;
  } vec_t;

  typedef struct {
    logic        en;
    logic        v;
    logic [15:0] a;
    logic [15:0] b;
    logic        ci;
    logic        sub;
  } cyc_t;

  vec_t tbl[12];
  cyc_t seq[$];

  pipe_addsub #(.WIDTH(16), .SEG(4)) dut (
    .ck(ck), .rst(rst), .en(en), .in_valid(in_valid),
    .a(a), .b(b), .ci(ci), .sub(sub),
    .out_valid(out_valid), .sum(sum), .co(co), .ovf(ovf)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag);
    chk({tag, "_vld"}, {31'd0, out_valid}, {31'd0, exp_ov});
    chk({tag, "_sum"}, {16'd0, sum}, {16'd0, exp_sum});
    chk({tag, "_co"}, {31'd0, co}, {31'd0, exp_co});
    chk({tag, "_ovf"}, {31'd0, ovf}, {31'd0, exp_ovf});
  endtask

  // Arithmetic reference in integers: returns {co, ovf, sum}.
  function automatic logic [17:0] ref_model(input logic [15:0] x, input logic [15:0] y,
                                            input logic c, input logic s);
    int ur;
    int sr;
    logic cout;
    logic ov;
    logic [15:0] r;
    if (s) begin
      ur   = int'(x) - int'(y) - int'(c);
      sr   = int'($signed(x)) - int'($signed(y)) - int'(c);
      cout = (ur >= 0);
    end else begin
      ur   = int'(x) + int'(y) + int'(c);
      sr   = int'($signed(x)) + int'($signed(y)) + int'(c);
      cout = (ur > 65535);
    end
    r  = ur[15:0];
    ov = (sr > 32767) || (sr < -32768);
    return {cout, ov, r};
  endfunction

  // Plays seq cycle by cycle; a delay line of enabled edges predicts the outputs.
  task automatic run_seq(input string tag);
    logic        dv[3];
    logic [17:0] dr[3];
    logic [17:0] r;
    for (int k = 0; k < 3; k++) begin
      dv[k] = 1'b0;
      dr[k] = 18'd0;
    end
    for (int t = 0; t < seq.size(); t++) begin
      en       = seq[t].en;
      in_valid = seq[t].v;
      a        = seq[t].a;
      b        = seq[t].b;
      ci       = seq[t].ci;
      sub      = seq[t].sub;
      r        = ref_model(seq[t].a, seq[t].b, seq[t].ci, seq[t].sub);
      tick();
      if (seq[t].en) begin
        exp_ov = dv[2];
        if (dv[2]) begin
          exp_sum = dr[2][15:0];
          exp_ovf = dr[2][16];
          exp_co  = dr[2][17];
        end
        dv[2] = dv[1]; dr[2] = dr[1];
        dv[1] = dv[0]; dr[1] = dr[0];
        dv[0] = seq[t].v; dr[0] = r;
      end
      chk_out($sformatf("%s_t%0d", tag, t));
    end
    en       = 1'b1;
    in_valid = 1'b0;
  endtask

  task automatic push_op(input logic e, input logic v);
    cyc_t c;
    c.en  = e;
    c.v   = v;
    c.a   = 16'($urandom);
    c.b   = 16'($urandom);
    c.ci  = 1'($urandom);
    c.sub = 1'($urandom);
    seq.push_back(c);
  endtask

  initial begin
    logic ov_early;
    checks   = 0;
    errors   = 0;
    rst      = 1'b0;
    en       = 1'b1;
    in_valid = 1'b0;
    a = 16'h0000; b = 16'h0000; ci = 1'b0; sub = 1'b0;
    exp_ov = 1'b0; exp_sum = 16'h0000; exp_co = 1'b0; exp_ovf = 1'b0;

    tbl[0]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    tbl[1]  = '{16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1};
    tbl[2]  = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    tbl[3]  = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    tbl[4]  = '{16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000E, 1'b1, 1'b0};
    tbl[5]  = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
    tbl[6]  = '{16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0};
    tbl[7]  = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
    tbl[8]  = '{16'h0000, 16'h0000, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0};
    tbl[9]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    tbl[10] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
    tbl[11] = '{16'h7FFF, 16'hFFFF, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1};

    // Power-on reset, then idle after release.
    #1 rst = 1'b1;
    #1 chk_out("por");
    @(posedge ck);
    #1 rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk_out($sformatf("por_idle%0d", k));
    end

    // Directed vectors, one at a time, checking latency and hold.
    for (int i = 0; i < 12; i++) begin
      a = tbl[i].a; b = tbl[i].b; ci = tbl[i].ci; sub = tbl[i].sub;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      a = 16'($urandom); b = 16'($urandom); ci = 1'($urandom); sub = 1'($urandom);
      ov_early = out_valid;
      tick();
      ov_early = ov_early | out_valid;
      tick();
      ov_early = ov_early | out_valid;
      chk($sformatf("vec%0d_early", i), {31'd0, ov_early}, 32'd0);
      tick();
      exp_ov = 1'b1; exp_sum = tbl[i].s; exp_co = tbl[i].co; exp_ovf = tbl[i].ovf;
      chk_out($sformatf("vec%0d", i));
      tick();
      exp_ov = 1'b0;
      chk_out($sformatf("vec%0d_hold", i));
    end

    // Streaming: 8 ops, 2 idle, 3 ops, drain.
    seq.delete();
    for (int k = 0; k < 8; k++) push_op(1'b1, 1'b1);
    for (int k = 0; k < 2; k++) push_op(1'b1, 1'b0);
    for (int k = 0; k < 3; k++) push_op(1'b1, 1'b1);
    for (int k = 0; k < 5; k++) push_op(1'b1, 1'b0);
    run_seq("strm");

    // Stall: 3 tokens in flight, EN low for 3 cycles (with valid-looking inputs), drain.
    seq.delete();
    for (int k = 0; k < 3; k++) push_op(1'b1, 1'b1);
    for (int k = 0; k < 3; k++) push_op(1'b0, 1'b1);
    for (int k = 0; k < 6; k++) push_op(1'b1, 1'b0);
    run_seq("stall");

    // Reset mid-clock with live outputs and random inputs.
    a = 16'h1234; b = 16'h1111; ci = 1'b0; sub = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    exp_ov = 1'b1; exp_sum = 16'h2345; exp_co = 1'b0; exp_ovf = 1'b0;
    chk_out("pre_rst");
    a = 16'($urandom); b = 16'($urandom); ci = 1'b1; sub = 1'($urandom); in_valid = 1'b1;
    #2 rst = 1'b1;
    exp_ov = 1'b0; exp_sum = 16'h0000; exp_co = 1'b0; exp_ovf = 1'b0;
    #1 chk_out("rst_async");
    tick();
    chk_out("rst_held");
    #2 rst = 1'b0;
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk_out($sformatf("rst_idle%0d", k));
    end

    // Reset mid-flight: tokens in the pipe must never emerge.
    for (int k = 0; k < 5; k++) begin
      a = 16'($urandom); b = 16'($urandom); ci = 1'($urandom); sub = 1'($urandom);
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    chk("flight_vld_before", {31'd0, out_valid}, 32'd1);
    #1 rst = 1'b1;
    #1 chk_out("flight_rst");
    #1 rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk_out($sformatf("flight_idle%0d", k));
    end
    a = 16'h0100; b = 16'h0023; ci = 1'b0; sub = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    ov_early = out_valid;
    tick();
    ov_early = ov_early | out_valid;
    tick();
    ov_early = ov_early | out_valid;
    chk("after_rst_early", {31'd0, ov_early}, 32'd0);
    tick();
    exp_ov = 1'b1; exp_sum = 16'h00DD; exp_co = 1'b1; exp_ovf = 1'b0;
    chk_out("after_rst_op");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1);
  end

endmodule
